// File: rtl/detector_jogada.sv
// detector_jogada: debounces the 4-bit player switches and turns each
// press/release pair into exactly one registered play, reported as a
// one-cycle jogada_feita (one-hot press) or jogada_invalida (anything else).
module detector_jogada #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic [3:0] chaves,
    output logic [3:0] jogada,
    output logic       jogada_feita,
    output logic       jogada_invalida,
    output logic [3:0] db_estado
);

    // Stability target, clamped into the 16-bit counter range (min 1 cycle).
    localparam int unsigned DEB_C  = (DEBOUNCE < 1) ? 1 :
                                     ((DEBOUNCE > 65535) ? 65535 : DEBOUNCE);
    localparam logic [15:0] DEB_M1 = 16'(DEB_C - 1);

    typedef enum logic [3:0] {
        OCIOSO   = 4'h0,
        FILTRA   = 4'h1,
        REGISTRA = 4'h2,
        SOLTA    = 4'h3
    } estado_t;

    estado_t     estado_q, estado_d;
    logic [3:0]  amostra_q, amostra_d;
    logic [15:0] cont_q, cont_d;
    logic [3:0]  jogada_q, jogada_d;
    logic        valido_q, valido_d;   // classification of the press held in REGISTRA
    logic        amostra_onehot;

    assign amostra_onehot = (amostra_q != 4'd0) && ((amostra_q & (amostra_q - 4'd1)) == 4'd0);

    // State and datapath registers; reset overrides everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            amostra_q <= 4'd0;
            cont_q    <= 16'd0;
            jogada_q  <= 4'd0;
            valido_q  <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            amostra_q <= amostra_d;
            cont_q    <= cont_d;
            jogada_q  <= jogada_d;
            valido_q  <= valido_d;
        end
    end

    // Next-state and datapath updates for press filtering and release wait.
    always_comb begin
        estado_d  = estado_q;
        amostra_d = amostra_q;
        cont_d    = cont_q;
        jogada_d  = jogada_q;
        valido_d  = valido_q;
        case (estado_q)
            OCIOSO: begin
                if (habilita && chaves != 4'd0) begin
                    estado_d  = FILTRA;
                    amostra_d = chaves;
                    cont_d    = 16'd0;
                end
            end
            FILTRA: begin
                if (!habilita || chaves == 4'd0) begin
                    estado_d = OCIOSO;
                end else if (chaves != amostra_q) begin
                    // bounce or a different key: restart the stability window
                    amostra_d = chaves;
                    cont_d    = 16'd0;
                end else if (cont_q == DEB_M1) begin
                    // classify on the edge entering REGISTRA
                    estado_d = REGISTRA;
                    valido_d = amostra_onehot;
                    if (amostra_onehot) jogada_d = amostra_q;
                end else begin
                    cont_d = cont_q + 16'd1;
                end
            end
            REGISTRA: begin
                estado_d = SOLTA;
                cont_d   = 16'd0;
            end
            SOLTA: begin
                if (chaves != 4'd0) begin
                    cont_d = 16'd0;
                end else if (cont_q == DEB_M1) begin
                    estado_d = OCIOSO;
                end else begin
                    cont_d = cont_q + 16'd1;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    // Moore pulses: REGISTRA lasts one cycle, the flag picks which pulse.
    assign jogada_feita    = (estado_q == REGISTRA) &&  valido_q;
    assign jogada_invalida = (estado_q == REGISTRA) && !valido_q;
    assign jogada          = jogada_q;
    assign db_estado       = estado_q;

endmodule
